led_pulse_stretcher: RTL and testbench
======================================

// Module: led_pulse_stretcher
// PURPOSE
//  Output-side counterpart of the switch debouncer. The debouncer turns slow, noisy human input into clean
//  single-clock signals; this block turns short internal events into blinks that are visible on an LED.
//  - Detects rising edges on event_in, e.g. a flip-flop q or a debounced clock pulse.
//  - Drives led_out high for a fixed number of cycles, then holds it low for a fixed gap.
//  - Sits between lab logic and board LEDs, clocked from the 50 MHz board clock.
// PARAMETERS
//  HOLD_CYCLES  12_500_000  LED-on time in clock cycles (250 ms at 50 MHz); legal range >=1
//  GAP_CYCLES   12_500_000  Forced LED-off time after each blink; 0 = no gap state
//  PEND_W       4           Width of the pending-event counter (used only with STRETCH_QUEUE_EN)
// PORTS
//  CLK50M       input   1       50 MHz board clock; all logic on the rising edge
//  reset        input   1       Synchronous, active-high reset
//  event_in     input   1       Event source, already synchronous to CLK50M; a rising edge is one event
//  led_out      output  1       Stretched pulse to the LED; registered
//  busy         output  1       1 while in state ON or GAP; registered
//  pending_cnt  output  PEND_W  Number of queued events not yet blinked; constant 0 without STRETCH_QUEUE_EN
// BEHAVIOUR
//  - Reset (sync, priority over everything):
//    - state=IDLE, cnt=0, led_out=0, busy=0, pending_cnt=0.
//    - The edge register evt_q loads 1, so a level held high through reset is NOT an event.
//  - Edge detect: evt_rise = event_in & ~evt_q; evt_q <= event_in every cycle.
//  - Counter: cnt is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits wide, unsigned, counts down, never wraps.
//  - FSM states: IDLE, ON, GAP.
//    - IDLE: on evt_rise -> ON, cnt<=HOLD_CYCLES-1, led_out<=1, busy<=1.
//      - Latency: edge sampled at cycle n -> led_out=1 from cycle n+1.
//    - ON: led_out=1 for exactly HOLD_CYCLES cycles. When cnt==0:
//      - If GAP_CYCLES>0: -> GAP, cnt<=GAP_CYCLES-1, led_out<=0.
//      - If GAP_CYCLES==0: treat as the end of GAP (rule below) in the same cycle.
//    - GAP: led_out=0 for exactly GAP_CYCLES cycles. When cnt==0:
//      - If pending_cnt>0: pending_cnt-1, -> ON, reload HOLD_CYCLES-1, led_out<=1.
//      - Else: -> IDLE, busy<=0.
//  - Events arriving in ON or GAP never restart or extend the current blink. Their handling depends on
//    the macro (see CONFIGURATION).
//  - Simultaneous events:
//    - An edge and a pending decrement in the same cycle: net pending_cnt is unchanged.
//    - An edge in the same cycle as GAP->IDLE is queued, so the FSM goes GAP->ON instead.
//  - Reset mid-blink: led_out drops to 0 in the next cycle; the queue is cleared.
// CONFIGURATION
//  Macro STRETCH_QUEUE_EN
//  - Defined:
//    - Each evt_rise seen in ON or GAP increments pending_cnt.
//    - pending_cnt saturates at 2**PEND_W-1; extra events are dropped silently.
//    - Queued events are replayed as separate blinks, each separated by the gap.
//  - Undefined:
//    - Events in ON or GAP are discarded.
//    - No pending register is synthesised; pending_cnt is tied to 0.
// TESTING  (bench params: HOLD_CYCLES=4, GAP_CYCLES=3, PEND_W=2)
//  1. Single event:
//     - Stimulus: event_in 0->1 sampled at cycle 10, held high.
//     - Required: led_out=1 for cycles 11-14, 0 for cycles 15-17; busy=1 for cycles 11-17; IDLE at cycle 18.
//     - Required: no second blink.
//  2. Reset level:
//     - Stimulus: event_in=1 throughout reset; reset released.
//     - Required: led_out stays 0; a 0->1 edge later blinks normally.
//  3. Event during ON, macro off:
//     - Stimulus: second edge at cycle 12.
//     - Required: one 4-cycle blink only; pending_cnt=0 throughout.
//  4. Queueing, macro on:
//     - Stimulus: edges at cycles 10, 12 and 16.
//     - Required: pending_cnt reaches 2; three blinks start at cycles 11, 18 and 25; busy falls at cycle 32.
//  5. Saturation, macro on:
//     - Stimulus: 5 edges during the first blink.
//     - Required: pending_cnt caps at 3; exactly 4 blinks total.
//  6. Mid-blink reset:
//     - Stimulus: reset asserted at cycle 13 during ON with pending_cnt=2.
//     - Required: at cycle 14 led_out=0, busy=0, pending_cnt=0; the next edge blinks with latency 1.

Source files
------------

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: turns short internal events into LED blinks that are
// long enough to see. A rising edge on event_in lights led_out for HOLD_CYCLES
// clocks, then forces it dark for GAP_CYCLES clocks before the next blink.
// Optional build macro: STRETCH_QUEUE_EN. When defined, edges that arrive
// while a blink is in progress are counted in pending_cnt (saturating) and
// replayed later as separate blinks. When undefined, those edges are dropped
// and pending_cnt is tied to zero.
module led_pulse_stretcher #(
    parameter int HOLD_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int PEND_W      = 4
) (
    input  logic              CLK50M,
    input  logic              reset,
    input  logic              event_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending_cnt
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1)
                                                              : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             led_nxt;
    logic             busy_nxt;
    logic             evt_q;
    logic             evt_rise;
    logic             blink_end;
    logic             replay;
    logic             have_pending;

    // Edge detect and end-of-blink decode shared by the FSM and the queue
    always_comb begin
        evt_rise  = event_in & ~evt_q;
        blink_end = 1'b0;
        if (state == GAP && cnt == '0) begin
            blink_end = 1'b1;
        end
        if (state == ON && cnt == '0 && GAP_CYCLES == 0) begin
            blink_end = 1'b1;
        end
    end

`ifdef STRETCH_QUEUE_EN
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_nxt;
    logic              queue_inc;

    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    // An edge landing exactly on the end of a blink counts as queued, so it
    // can be replayed immediately even when the queue was empty
    always_comb begin
        have_pending = (pend_q != '0);
        replay       = blink_end & (have_pending | evt_rise);
        queue_inc    = evt_rise & (state != IDLE);
        pend_nxt     = pend_q;
        if (queue_inc && !replay) begin
            if (pend_q != PEND_MAX) begin
                pend_nxt = pend_q + PEND_ONE;
            end
        end else if (replay && !queue_inc) begin
            pend_nxt = pend_q - PEND_ONE;
        end
    end

    // Pending-event counter register, cleared by reset
    always_ff @(posedge CLK50M) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    assign pending_cnt = pend_q;
`else
    // Without the queue nothing is ever replayed
    always_comb begin
        have_pending = 1'b0;
        replay       = 1'b0;
    end

    assign pending_cnt = '0;
`endif

    // Next-state logic: IDLE waits for an edge, ON and GAP count down to zero
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        led_nxt   = led_out;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (evt_rise) begin
                    state_nxt = ON;
                    cnt_nxt   = HOLD_LOAD;
                    led_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            ON: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (!blink_end) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                    led_nxt   = 1'b0;
                end else if (replay) begin
                    state_nxt = ON;
                    cnt_nxt   = HOLD_LOAD;
                    led_nxt   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    led_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (replay) begin
                    state_nxt = ON;
                    cnt_nxt   = HOLD_LOAD;
                    led_nxt   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    led_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                led_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register; evt_q loads 1 in reset so a level held through reset is not an edge
    always_ff @(posedge CLK50M) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            led_out <= 1'b0;
            busy    <= 1'b0;
            evt_q   <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            led_out <= led_nxt;
            busy    <= busy_nxt;
            evt_q   <= event_in;
        end
    end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher: directed scenarios with literal expectations plus a
// long randomized run, all checked every cycle against a timeline model.
// Honours STRETCH_QUEUE_EN the same way the design does.
module tb_led_pulse_stretcher;

    localparam int HOLD   = 4;
    localparam int GAP    = 3;
    localparam int PW     = 2;
    localparam int PERIOD = HOLD + GAP;
    localparam int PMAX   = (1 << PW) - 1;

    logic          CLK50M;
    logic          reset;
    logic          event_in;
    logic          led_out;
    logic          busy;
    logic [PW-1:0] pending_cnt;

    int checks   = 0;
    int failures = 0;

    led_pulse_stretcher #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .PEND_W     (PW)
    ) dut (
        .CLK50M     (CLK50M),
        .reset      (reset),
        .event_in   (event_in),
        .led_out    (led_out),
        .busy       (busy),
        .pending_cnt(pending_cnt)
    );

    // 50 MHz clock
    initial begin
        CLK50M = 1'b0;
        forever #10 CLK50M = ~CLK50M;
    end

    // Model: a blink is a time window [m_start, m_start+PERIOD-1]; the LED is
    // lit for the first HOLD cycles of that window
    int mcyc    = 0;
    int m_start = 0;
    int m_pend  = 0;
    int m_inc;
    int m_dec;
    bit m_active    = 1'b0;
    bit m_prev      = 1'b1;
    bit m_rise;
    bit model_valid = 1'b0;
    bit exp_led     = 1'b0;
    bit exp_busy    = 1'b0;
    int exp_pend    = 0;

    // Advance the model on each rising edge using the inputs the DUT samples
    always @(posedge CLK50M) begin
        m_rise = event_in && !m_prev;
        if (reset) begin
            m_active = 1'b0;
            m_pend   = 0;
            m_prev   = 1'b1;
        end else begin
            m_prev = event_in;
            if (!m_active) begin
                if (m_rise) begin
                    m_active = 1'b1;
                    m_start  = mcyc + 1;
                end
            end else begin
`ifdef STRETCH_QUEUE_EN
                m_inc = m_rise ? 1 : 0;
`else
                m_inc = 0;
`endif
                m_dec = 0;
                if (mcyc == m_start + PERIOD - 1) begin
                    if (m_pend + m_inc > 0) begin
                        m_dec   = 1;
                        m_start = mcyc + 1;
                    end else begin
                        m_active = 1'b0;
                    end
                end
                m_pend = m_pend + m_inc - m_dec;
                if (m_pend > PMAX) m_pend = PMAX;
            end
        end
        exp_led     = m_active && ((mcyc + 1 - m_start) < HOLD);
        exp_busy    = m_active;
        exp_pend    = m_pend;
        mcyc        = mcyc + 1;
        model_valid = 1'b1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Compare DUT outputs against the model on every falling edge
    always @(negedge CLK50M) begin
        if (model_valid) begin
            checkOutput("model_led", int'(led_out), int'(exp_led));
            checkOutput("model_busy", int'(busy), int'(exp_busy));
            checkOutput("model_pend", int'(pending_cnt), exp_pend);
        end
    end

    // Drive one cycle of inputs; on return outputs show the cycle after sampling
    task automatic applyStimulus(input logic rst, input logic ev);
        reset    = rst;
        event_in = ev;
        @(negedge CLK50M);
    endtask

    bit led_s  [0:39];
    bit busy_s [0:39];
    int pmax;
    int blinks;

    task automatic recordPattern(input logic [39:0] pat, input int n);
        bit prev_led;
        prev_led = led_out;
        pmax     = 0;
        blinks   = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, pat[i]);
            led_s[i]  = led_out;
            busy_s[i] = busy;
            if (int'(pending_cnt) > pmax) pmax = int'(pending_cnt);
            if (led_out && !prev_led) blinks = blinks + 1;
            prev_led = led_out;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    logic ev_r;

    initial begin
        reset    = 1'b1;
        event_in = 1'b0;
        @(negedge CLK50M);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset_led", int'(led_out), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_pend", int'(pending_cnt), 0);
        idleCycles(3);

        // Single event held high: 4 on, 3 gap, then idle, no second blink
        begin
            logic [39:0] pat;
            pat = '1;
            recordPattern(pat, 20);
        end
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("single_led[%0d]", i), int'(led_s[i]), (i < HOLD) ? 1 : 0);
            checkOutput($sformatf("single_busy[%0d]", i), int'(busy_s[i]), (i < PERIOD) ? 1 : 0);
        end
        checkOutput("single_blinks", blinks, 1);

        // Level held high through reset is not an event
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        begin
            logic [39:0] pat;
            pat = '1;
            recordPattern(pat, 8);
        end
        checkOutput("rstlevel_blinks", blinks, 0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("rstlevel_edge_led", int'(led_out), 1);
        idleCycles(10);

        // Edges at offsets 0, 2 and 6
        recordPattern(40'h45, 26);
`ifdef STRETCH_QUEUE_EN
        checkOutput("queue_pmax", pmax, 2);
        checkOutput("queue_blinks", blinks, 3);
        checkOutput("queue_led0", int'(led_s[0]), 1);
        checkOutput("queue_led6", int'(led_s[6]), 0);
        checkOutput("queue_led7", int'(led_s[7]), 1);
        checkOutput("queue_led13", int'(led_s[13]), 0);
        checkOutput("queue_led14", int'(led_s[14]), 1);
        checkOutput("queue_busy20", int'(busy_s[20]), 1);
        checkOutput("queue_busy21", int'(busy_s[21]), 0);
`else
        checkOutput("drop_pmax", pmax, 0);
        checkOutput("drop_blinks", blinks, 1);
        checkOutput("drop_busy6", int'(busy_s[6]), 1);
        checkOutput("drop_busy7", int'(busy_s[7]), 0);
`endif
        idleCycles(4);

        // Seven edges two cycles apart: queue saturates and extra edges drop
        recordPattern(40'h1555, 40);
`ifdef STRETCH_QUEUE_EN
        checkOutput("sat_pmax", pmax, PMAX);
        checkOutput("sat_blinks", blinks, 5);
        checkOutput("sat_led28", int'(led_s[28]), 1);
        checkOutput("sat_busy34", int'(busy_s[34]), 1);
        checkOutput("sat_busy35", int'(busy_s[35]), 0);
`else
        checkOutput("sat_off_pmax", pmax, 0);
        checkOutput("sat_off_blinks", blinks, 2);
`endif
        idleCycles(4);

        // Reset in the middle of a blink
        recordPattern(40'h55, 8);
`ifdef STRETCH_QUEUE_EN
        checkOutput("midrst_pre_pend", int'(pending_cnt), 2);
        checkOutput("midrst_pre_led", int'(led_out), 1);
`else
        checkOutput("midrst_pre_busy", int'(busy), 0);
`endif
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst_led", int'(led_out), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_pend", int'(pending_cnt), 0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("midrst_next_led", int'(led_out), 1);
        idleCycles(10);

        // Randomized run against the model
        ev_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) ev_r = ~ev_r;
            applyStimulus(($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0, ev_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
